alu_result_checker: RTL and testbench

//   Self-checking receive end for ALU stimulus benches: the stimulus side pushes

---
 rtl/alu_result_checker.sv | 133 +++++++++++++
 tb/tb_alu_result_checker.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// In-order result checker: expected values queue in a small FIFO and are compared against
// valid-qualified ALU samples, reporting mismatches, underruns and an end-of-run pass flag.
module alu_result_checker #(
   parameter int unsigned W     = 9,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_total,
   input  logic             exp_valid,
   input  logic [W-1:0]     exp_data,
   output logic             exp_ready,
   input  logic             act_valid,
   input  logic [W-1:0]     act_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [W-1:0]     mismatch_exp,
   output logic [W-1:0]     mismatch_act,
   output logic             underrun,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] cmp_count
);

   localparam int unsigned PW = $clog2(DEPTH);

   typedef logic [PW:0]      ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         state_q;
   ptr_t           wr_ptr_q, rd_ptr_q;
   logic [W-1:0]   mem_q [DEPTH];
   cnt_t           n_total_q, err_count_q, cmp_count_q;
   logic           underrun_q, mismatch_q;
   logic [W-1:0]   mismatch_exp_q, mismatch_act_q;

   logic           is_run, active, full, empty, push, pop, under_evt, cmp_fail, err_evt;
   logic [W-1:0]   head;
   cnt_t           cmp_next;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

   assign is_run    = (state_q == StRun);
   // Guards n_total==0 runs so cmp_count never passes n_total.
   assign active    = is_run && (cmp_count_q != n_total_q);
   assign exp_ready = is_run && !full;
   assign push      = exp_valid && exp_ready;
   // Compares only see entries stored before this edge.
   assign pop       = active && act_valid && !empty;
   assign under_evt = active && act_valid && empty;
   assign head      = mem_q[rd_ptr_q[PW-1:0]];
   assign cmp_fail  = pop && (head != act_data);
   assign err_evt   = cmp_fail || under_evt;
   assign cmp_next  = (pop || under_evt) ? cmp_count_q + cnt_t'(1) : cmp_count_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= exp_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         n_total_q      <= '0;
         err_count_q    <= '0;
         cmp_count_q    <= '0;
         underrun_q     <= 1'b0;
         mismatch_q     <= 1'b0;
         mismatch_exp_q <= '0;
         mismatch_act_q <= '0;
      end else begin
         mismatch_q <= cmp_fail;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q        <= StRun;
                  n_total_q      <= n_total;
                  wr_ptr_q       <= '0;
                  rd_ptr_q       <= '0;
                  err_count_q    <= '0;
                  cmp_count_q    <= '0;
                  underrun_q     <= 1'b0;
                  mismatch_exp_q <= '0;
                  mismatch_act_q <= '0;
               end
            end
            StRun: begin
               if (push) begin
                  wr_ptr_q <= wr_ptr_q + ptr_t'(1);
               end
               if (pop) begin
                  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
               end
               if (cmp_fail) begin
                  mismatch_exp_q <= head;
                  mismatch_act_q <= act_data;
               end
               if (under_evt) begin
                  underrun_q <= 1'b1;
               end
               if (err_evt && (err_count_q != '1)) begin
                  err_count_q <= err_count_q + cnt_t'(1);
               end
               cmp_count_q <= cmp_next;
               if (cmp_next == n_total_q) begin
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy         = is_run;
   assign done         = (state_q == StDone);
   assign pass         = done && (err_count_q == '0) && !underrun_q && empty;
   assign mismatch     = mismatch_q;
   assign mismatch_exp = mismatch_exp_q;
   assign mismatch_act = mismatch_act_q;
   assign underrun     = underrun_q;
   assign err_count    = err_count_q;
   assign cmp_count    = cmp_count_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: directed scenarios plus randomized runs against a
// queue-based reference model.
module tb_alu_result_checker;

   localparam int W     = 9;
   localparam int DEPTH = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] n_total;
   logic             exp_valid;
   logic [W-1:0]     exp_data;
   logic             exp_ready;
   logic             act_valid;
   logic [W-1:0]     act_data;
   logic             busy, done, pass, mismatch, underrun;
   logic [W-1:0]     mismatch_exp, mismatch_act;
   logic [CNT_W-1:0] err_count, cmp_count;

   int errors = 0;
   int checks = 0;

   // Reference model: mode 0 idle, 1 running, 2 finished.
   int           m_mode;
   logic [W-1:0] m_q[$];
   int           m_ntot, m_cmp, m_err;
   bit           m_under, m_mm;
   logic [W-1:0] m_mexp, m_mact;

   logic [37:0] dut_vec;
   assign dut_vec = {busy, done, pass, mismatch, underrun, exp_ready, err_count, cmp_count};

   alu_result_checker #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .n_total      (n_total),
      .exp_valid    (exp_valid),
      .exp_data     (exp_data),
      .exp_ready    (exp_ready),
      .act_valid    (act_valid),
      .act_data     (act_data),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .mismatch     (mismatch),
      .mismatch_exp (mismatch_exp),
      .mismatch_act (mismatch_act),
      .underrun     (underrun),
      .err_count    (err_count),
      .cmp_count    (cmp_count)
   );

   always #5 clk = ~clk;

   function automatic logic [37:0] model_vec();
      bit m_pass;
      m_pass = (m_mode == 2) && (m_err == 0) && !m_under && (m_q.size() == 0);
      return {m_mode == 1, m_mode == 2, m_pass, m_mm, m_under,
              (m_mode == 1) && (m_q.size() < DEPTH), 16'(m_err), 16'(m_cmp)};
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_cmp   = 0;
      m_err   = 0;
      m_under = 0;
      m_mm    = 0;
      m_mexp  = '0;
      m_mact  = '0;
   endtask

   // Drives one cycle of inputs (called at posedge+1) and advances the model across that edge.
   task automatic step(input bit st, input int nt, input bit ev, input logic [W-1:0] ed,
                       input bit av, input logic [W-1:0] ad);
      bit           acc;
      logic [W-1:0] e;
      start     = st;
      n_total   = 16'(nt);
      exp_valid = ev;
      exp_data  = ed;
      act_valid = av;
      act_data  = ad;
      m_mm = 0;
      if (m_mode != 1) begin
         if (st) begin
            model_clear();
            m_mode = 1;
            m_ntot = nt;
         end
      end else begin
         acc = ev && (m_q.size() < DEPTH);
         if (av && (m_cmp < m_ntot)) begin
            m_cmp++;
            if (m_q.size() == 0) begin
               m_under = 1;
               if (m_err < 65535) m_err++;
            end else begin
               e = m_q.pop_front();
               if (e !== ad) begin
                  m_mm   = 1;
                  m_mexp = e;
                  m_mact = ad;
                  if (m_err < 65535) m_err++;
               end
            end
         end
         if (acc) m_q.push_back(ed);
         if (m_cmp == m_ntot) m_mode = 2;
      end
      @(posedge clk);
      #1;
      start     = 1'b0;
      exp_valid = 1'b0;
      act_valid = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({dut_vec, mismatch_exp, mismatch_act} !== '0) begin
         $display("FAIL reset got=%h/%h/%h want=0", dut_vec, mismatch_exp, mismatch_act);
         errors++;
      end
   endtask

   task automatic test_in_order();
      step(1, 8, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 9'(7 - i), 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 9'(7 - i));
      checks++;
      if ({done, pass, err_count, cmp_count} !== {1'b1, 1'b1, 16'd0, 16'd8}) begin
         $display("FAIL in_order got done=%b pass=%b err=%0d cmp=%0d want 1 1 0 8",
                  done, pass, err_count, cmp_count);
         errors++;
      end
      checks++;
      if (dut_vec !== model_vec()) begin
         $display("FAIL in_order_model got=%h want=%h", dut_vec, model_vec());
         errors++;
      end
   endtask

   task automatic test_mismatch();
      int pulses;
      pulses = 0;
      step(1, 8, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 9'(7 - i), 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 0, 1, (i == 3) ? 9'h1FF : 9'(7 - i));
         if (mismatch === 1'b1) pulses++;
         checks++;
         if (mismatch !== m_mm) begin
            $display("FAIL mismatch_pulse i=%0d got=%b want=%b", i, mismatch, m_mm);
            errors++;
         end
      end
      checks++;
      if ({pulses[3:0], mismatch_exp, mismatch_act, err_count, pass, done} !==
          {4'd1, 9'd4, 9'h1FF, 16'd1, 1'b0, 1'b1}) begin
         $display("FAIL mismatch_capture got pulses=%0d exp=%h act=%h err=%0d pass=%b done=%b",
                  pulses, mismatch_exp, mismatch_act, err_count, pass, done);
         errors++;
      end
   endtask

   task automatic test_full();
      logic [W-1:0] d [9];
      step(1, 9, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         d[i] = 9'($urandom);
         step(0, 0, 1, d[i], 0, 0);
         checks++;
         if (exp_ready !== (i < 7)) begin
            $display("FAIL full_ready push=%0d got=%b want=%b", i + 1, exp_ready, i < 7);
            errors++;
         end
      end
      d[8] = 9'($urandom);
      step(0, 0, 1, d[8], 0, 0);
      checks++;
      if ({exp_ready, dut_vec} !== {1'b0, model_vec()}) begin
         $display("FAIL full_hold got=%h want=%h", dut_vec, model_vec());
         errors++;
      end
      step(0, 0, 1, d[8], 1, d[0]);
      checks++;
      if ({exp_ready, cmp_count} !== {1'b1, 16'd1}) begin
         $display("FAIL full_pop got ready=%b cmp=%0d want 1 1", exp_ready, cmp_count);
         errors++;
      end
      step(0, 0, 1, d[8], 0, 0);
      checks++;
      if (exp_ready !== 1'b0) begin
         $display("FAIL full_refill got ready=%b want 0", exp_ready);
         errors++;
      end
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, m_q[0]);
      checks++;
      if ({done, pass, err_count, cmp_count} !== {1'b1, 1'b1, 16'd0, 16'd9}) begin
         $display("FAIL full_drain got done=%b pass=%b err=%0d cmp=%0d want 1 1 0 9",
                  done, pass, err_count, cmp_count);
         errors++;
      end
   endtask

   task automatic test_underrun();
      step(1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 9'h055, 1, 9'h055);
      checks++;
      if ({underrun, err_count, cmp_count, done, pass} !== {1'b1, 16'd1, 16'd1, 1'b1, 1'b0}) begin
         $display("FAIL underrun got u=%b err=%0d cmp=%0d done=%b pass=%b want 1 1 1 1 0",
                  underrun, err_count, cmp_count, done, pass);
         errors++;
      end
   endtask

   task automatic test_reset_mid_run();
      step(1, 6, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 9'(i * 3), 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, m_q[0]);
      checks++;
      if (cmp_count !== 16'd3) begin
         $display("FAIL midrun_pre got cmp=%0d want 3", cmp_count);
         errors++;
      end
      #2 rst = 1'b1;
      #1;
      model_clear();
      m_mode = 0;
      checks++;
      if ({busy, done, exp_ready, err_count, cmp_count} !== '0) begin
         $display("FAIL midrun_reset got busy=%b done=%b ready=%b err=%0d cmp=%0d want 0",
                  busy, done, exp_ready, err_count, cmp_count);
         errors++;
      end
      @(posedge clk);
      #1 rst = 1'b0;
      step(1, 2, 0, 0, 0, 0);
      step(0, 0, 1, 9'h1A0, 0, 0);
      step(0, 0, 1, 9'h00B, 0, 0);
      step(0, 0, 0, 0, 1, 9'h1A0);
      step(0, 0, 0, 0, 1, 9'h00B);
      checks++;
      if ({done, pass, cmp_count} !== {1'b1, 1'b1, 16'd2}) begin
         $display("FAIL midrun_rerun got done=%b pass=%b cmp=%0d want 1 1 2", done, pass, cmp_count);
         errors++;
      end
   endtask

   task automatic test_leftover();
      step(1, 2, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 9'(100 + i), 0, 0);
      step(0, 0, 0, 0, 1, 9'd100);
      step(0, 0, 0, 0, 1, 9'd101);
      checks++;
      if ({done, pass, err_count} !== {1'b1, 1'b0, 16'd0}) begin
         $display("FAIL leftover got done=%b pass=%b err=%0d want 1 0 0", done, pass, err_count);
         errors++;
      end
   endtask

   task automatic test_random();
      int           n, cyc;
      bit           av, ev, st;
      logic [W-1:0] ad;
      for (int r = 0; r < 12; r++) begin
         n = (r == 0) ? 0 : $urandom_range(1, 14);
         step(1, n, 0, 0, 0, 0);
         cyc = 0;
         while (cyc < 300) begin
            checks++;
            if ({dut_vec, mismatch_exp, mismatch_act} !== {model_vec(), m_mexp, m_mact}) begin
               $display("FAIL random r=%0d cyc=%0d got=%h/%h/%h want=%h/%h/%h", r, cyc, dut_vec,
                        mismatch_exp, mismatch_act, model_vec(), m_mexp, m_mact);
               errors++;
            end
            if (m_mode != 1) break;
            ev = ($urandom_range(0, 2) != 0);
            av = ($urandom_range(0, 1) != 0);
            st = ($urandom_range(0, 15) == 0);
            ad = (m_q.size() > 0 && $urandom_range(0, 3) != 0) ? m_q[0] : 9'($urandom);
            step(st, $urandom_range(0, 5), ev, 9'($urandom), av, ad);
            cyc++;
         end
         checks++;
         if (m_mode != 2) begin
            $display("FAIL random_timeout r=%0d cmp=%0d want done", r, cmp_count);
            errors++;
         end
         // Samples after the run must be ignored.
         step(0, 0, 1, 9'h0AA, 1, 9'h155);
         checks++;
         if (dut_vec !== model_vec()) begin
            $display("FAIL random_idle r=%0d got=%h want=%h", r, dut_vec, model_vec());
            errors++;
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      n_total   = '0;
      exp_valid = 1'b0;
      exp_data  = '0;
      act_valid = 1'b0;
      act_data  = '0;
      m_mode    = 0;
      m_ntot    = 0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      test_in_order();
      test_mismatch();
      test_full();
      test_underrun();
      test_reset_mid_run();
      test_leftover();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
